// File: rtl/hls_prof_pkg.sv
// Shared types and helpers for the HLS handshake profiler.
// Statistics travel between channel and top in a fixed maximum-width struct
// (counters up to 64 bits, latency up to 32 bits); the used low bits are
// selected by the CNT_W / LAT_W parameters of the instantiating module.
package hls_prof_pkg;

    localparam int CNT_MAX_W = 64;
    localparam int LAT_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] txn;
        logic [CNT_MAX_W-1:0] ready_cnt;
        logic [CNT_MAX_W-1:0] busy;
        logic [CNT_MAX_W-1:0] stall;
        logic [LAT_MAX_W-1:0] lat_min;
        logic [LAT_MAX_W-1:0] lat_max;
        logic                 ovf;
    } ch_stats_t;

    // Minimum latency before any completed transaction.
    localparam logic [LAT_MAX_W-1:0] LAT_INIT = '1;

    // Increment that sticks at 'ones' instead of wrapping.
    function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] v,
                                                     input logic [CNT_MAX_W-1:0] ones);
        return (v >= ones) ? ones : v + 64'd1;
    endfunction

endpackage

// File: rtl/hls_prof_channel.sv
// One monitored ap_ctrl handshake: IDLE/RUN/WAIT_CONT tracker plus its
// saturating statistics. hold_i freezes statistics only; the FSM keeps tracking.
module hls_prof_channel
    import hls_prof_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LAT_W = 16
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clear_i,
    input  logic      hold_i,
    input  logic      ap_start_i,
    input  logic      ap_ready_i,
    input  logic      ap_done_i,
    input  logic      ap_continue_i,
    output ch_stats_t stats_o,
    output logic      start_evt_o,
    output logic      done_evt_o
);

    localparam logic [CNT_MAX_W-1:0] CNT_ONES = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_MAX_W-1:0] LAT_ONES = (64'd1 << LAT_W) - 64'd1;
    localparam logic [LAT_W-1:0]     LAT_RST  = LAT_W'(LAT_INIT);

    ch_state_e        state_q;
    logic [LAT_W-1:0] lat_q, lat_cur;
    logic [LAT_W-1:0] min_q, min_d, max_q, max_d;
    logic [CNT_W-1:0] txn_q, txn_d, rdy_q, rdy_d, busy_q, busy_d, stall_q, stall_d;
    logic [CNT_W-1:0] txn_nxt, rdy_nxt, busy_nxt, stall_nxt;
    logic             ovf_q, ovf_d;
    logic             busy_inc, stall_inc, txn_inc, lat_upd, start_evt;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(64'(v), CNT_ONES));
    endfunction

    // Latency including the current cycle.
    assign lat_cur = LAT_W'(sat_inc(64'(lat_q), LAT_ONES));

    // Decode this cycle's events from the current state and handshake inputs.
    always_comb begin
        busy_inc  = 1'b0;
        stall_inc = 1'b0;
        txn_inc   = 1'b0;
        lat_upd   = 1'b0;
        start_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ap_done while idle is ignored
                if (ap_start_i) begin
                    busy_inc  = 1'b1;
                    start_evt = 1'b1;
                end
            end
            RUN: begin
                busy_inc = 1'b1;
                if (ap_done_i) begin
                    lat_upd = 1'b1;
                    if (ap_continue_i) begin
                        txn_inc   = 1'b1;
                        start_evt = ap_start_i;
                    end
                end
            end
            WAIT_CONT: begin
                if (!ap_continue_i) begin
                    stall_inc = 1'b1;
                end else begin
                    txn_inc   = 1'b1;
                    busy_inc  = ap_start_i;
                    start_evt = ap_start_i;
                end
            end
            default: ;
        endcase
    end

    // Handshake FSM and the running latency counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE:      if (ap_start_i) state_q <= RUN;
                RUN: begin
                    if (ap_done_i) begin
                        if (!ap_continue_i)  state_q <= WAIT_CONT;
                        else if (!ap_start_i) state_q <= IDLE;
                    end
                end
                WAIT_CONT: begin
                    if (ap_continue_i) state_q <= ap_start_i ? RUN : IDLE;
                end
                default:   state_q <= IDLE;
            endcase
            // clear restarts partial runs from zero so they do not skew latency
            if (clear_i)               lat_q <= '0;
            else if (start_evt)        lat_q <= LAT_W'(1);
            else if (state_q == RUN)   lat_q <= lat_cur;
        end
    end

    assign txn_nxt   = cnt_inc(txn_q);
    assign rdy_nxt   = cnt_inc(rdy_q);
    assign busy_nxt  = cnt_inc(busy_q);
    assign stall_nxt = cnt_inc(stall_q);

    // Next-state statistics: clear beats freeze, freeze blocks every update.
    always_comb begin
        txn_d   = txn_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        stall_d = stall_q;
        min_d   = min_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            txn_d   = '0;
            rdy_d   = '0;
            busy_d  = '0;
            stall_d = '0;
            min_d   = LAT_RST;
            max_d   = '0;
            ovf_d   = 1'b0;
        end else if (!hold_i) begin
            if (txn_inc)    txn_d   = txn_nxt;
            if (ap_ready_i) rdy_d   = rdy_nxt;
            if (busy_inc)   busy_d  = busy_nxt;
            if (stall_inc)  stall_d = stall_nxt;
            if (lat_upd && lat_cur < min_q) min_d = lat_cur;
            if (lat_upd && lat_cur > max_q) max_d = lat_cur;
            ovf_d = ovf_q
                  | (txn_inc    && txn_nxt   == CNT_W'(CNT_ONES))
                  | (ap_ready_i && rdy_nxt   == CNT_W'(CNT_ONES))
                  | (busy_inc   && busy_nxt  == CNT_W'(CNT_ONES))
                  | (stall_inc  && stall_nxt == CNT_W'(CNT_ONES));
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_q   <= '0;
            rdy_q   <= '0;
            busy_q  <= '0;
            stall_q <= '0;
            min_q   <= LAT_RST;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            txn_q   <= txn_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            min_q   <= min_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end

    // Zero-extend into the shared max-width struct.
    always_comb begin
        stats_o           = '0;
        stats_o.txn       = 64'(txn_q);
        stats_o.ready_cnt = 64'(rdy_q);
        stats_o.busy      = 64'(busy_q);
        stats_o.stall     = 64'(stall_q);
        stats_o.lat_min   = 32'(min_q);
        stats_o.lat_max   = 32'(max_q);
        stats_o.ovf       = ovf_q;
    end

    assign start_evt_o = start_evt;
    assign done_evt_o  = txn_inc;

endmodule

// File: rtl/hls_handshake_profiler.sv
// Per-channel profiler for HLS ap_start/ap_ready/ap_done/ap_continue
// handshakes with a registered one-cycle readout port.
// Optional macro HLS_PROF_TIMESTAMP_EN adds a cycle counter and per-channel
// first-start / last-done timestamps (rd_first_start_o, rd_last_done_o).
module hls_handshake_profiler
    import hls_prof_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int LAT_W    = 16,
    parameter int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                finish_i,
    input  logic                clear_i,
    input  logic [NUM_CH-1:0]   ap_start_i,
    input  logic [NUM_CH-1:0]   ap_ready_i,
    input  logic [NUM_CH-1:0]   ap_done_i,
    input  logic [NUM_CH-1:0]   ap_continue_i,
    input  logic                rd_req_i,
    input  logic [CH_IDX_W-1:0] rd_ch_i,
    output logic                rd_valid_o,
    output logic                rd_err_o,
    output logic [CNT_W-1:0]    rd_txn_o,
    output logic [CNT_W-1:0]    rd_ready_cnt_o,
    output logic [CNT_W-1:0]    rd_busy_o,
    output logic [CNT_W-1:0]    rd_stall_o,
    output logic [LAT_W-1:0]    rd_lat_min_o,
    output logic [LAT_W-1:0]    rd_lat_max_o,
    output logic                rd_ovf_o,
`ifdef HLS_PROF_TIMESTAMP_EN
    output logic [CNT_W-1:0]    rd_first_start_o,
    output logic [CNT_W-1:0]    rd_last_done_o,
`endif
    output logic                frozen_o
);

    localparam logic [CH_IDX_W:0] NUM_CH_L = (CH_IDX_W+1)'(NUM_CH);

    ch_stats_t         stats [NUM_CH];
    ch_stats_t         sel;
    logic [NUM_CH-1:0] start_evt, done_evt;
    logic              frozen_q, hold, in_range;
    logic              unused_sel;

    logic              rd_valid_q, rd_err_q, rd_ovf_q;
    logic [CNT_W-1:0]  rd_txn_q, rd_rdy_q, rd_busy_q, rd_stall_q;
    logic [LAT_W-1:0]  rd_min_q, rd_max_q;

    // finish takes effect in its own cycle, not one later
    assign hold = frozen_q | finish_i;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hls_prof_channel #(
            .CNT_W (CNT_W),
            .LAT_W (LAT_W)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .clear_i       (clear_i),
            .hold_i        (hold),
            .ap_start_i    (ap_start_i[g]),
            .ap_ready_i    (ap_ready_i[g]),
            .ap_done_i     (ap_done_i[g]),
            .ap_continue_i (ap_continue_i[g]),
            .stats_o       (stats[g]),
            .start_evt_o   (start_evt[g]),
            .done_evt_o    (done_evt[g])
        );
    end

    // Sticky freeze flag; clear wins over a simultaneous finish.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       frozen_q <= 1'b0;
        else if (clear_i)  frozen_q <= 1'b0;
        else if (finish_i) frozen_q <= 1'b1;
    end

`ifdef HLS_PROF_TIMESTAMP_EN
    localparam logic [CNT_MAX_W-1:0] CNT_ONES = (64'd1 << CNT_W) - 64'd1;

    logic [CNT_W-1:0]              cyc_q;
    logic [NUM_CH-1:0]             fs_vld_q;
    logic [NUM_CH-1:0][CNT_W-1:0]  fs_q, ld_q;
    logic [CNT_W-1:0]              sel_fs, sel_ld, rd_fs_q, rd_ld_q;

    // Cycle counter and first-start / last-done capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q    <= '0;
            fs_vld_q <= '0;
            fs_q     <= '0;
            ld_q     <= '0;
        end else if (clear_i) begin
            cyc_q    <= '0;
            fs_vld_q <= '0;
            fs_q     <= '0;
            ld_q     <= '0;
        end else if (!hold) begin
            cyc_q <= CNT_W'(sat_inc(64'(cyc_q), CNT_ONES));
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_evt[i] && !fs_vld_q[i]) begin
                    fs_q[i]     <= cyc_q;
                    fs_vld_q[i] <= 1'b1;
                end
                if (done_evt[i]) ld_q[i] <= cyc_q;
            end
        end
    end

    // Timestamp readout mux; zero for an out-of-range channel.
    always_comb begin
        sel_fs = '0;
        sel_ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_i == CH_IDX_W'(i)) begin
                sel_fs = fs_q[i];
                sel_ld = ld_q[i];
            end
        end
    end

    // Timestamp readout registers, same timing as the statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_fs_q <= '0;
            rd_ld_q <= '0;
        end else if (rd_req_i) begin
            rd_fs_q <= sel_fs;
            rd_ld_q <= sel_ld;
        end
    end

    assign rd_first_start_o = rd_fs_q;
    assign rd_last_done_o   = rd_ld_q;
`else
    logic unused_evt;
    assign unused_evt = ^{start_evt, done_evt};
`endif

    // Statistics readout mux; no match leaves zeros for out-of-range channels.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch_i == CH_IDX_W'(i)) sel = stats[i];
        end
    end

    assign in_range   = {1'b0, rd_ch_i} < NUM_CH_L;
    assign unused_sel = ^sel;

    // One-cycle readout: snapshot on rd_req, data held until the next request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_txn_q   <= '0;
            rd_rdy_q   <= '0;
            rd_busy_q  <= '0;
            rd_stall_q <= '0;
            rd_min_q   <= '0;
            rd_max_q   <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_err_q   <= !in_range;
                rd_txn_q   <= CNT_W'(sel.txn);
                rd_rdy_q   <= CNT_W'(sel.ready_cnt);
                rd_busy_q  <= CNT_W'(sel.busy);
                rd_stall_q <= CNT_W'(sel.stall);
                rd_min_q   <= LAT_W'(sel.lat_min);
                rd_max_q   <= LAT_W'(sel.lat_max);
                rd_ovf_q   <= sel.ovf;
            end
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rd_err_o       = rd_err_q;
    assign rd_txn_o       = rd_txn_q;
    assign rd_ready_cnt_o = rd_rdy_q;
    assign rd_busy_o      = rd_busy_q;
    assign rd_stall_o     = rd_stall_q;
    assign rd_lat_min_o   = rd_min_q;
    assign rd_lat_max_o   = rd_max_q;
    assign rd_ovf_o       = rd_ovf_q;
    assign frozen_o       = frozen_q;

endmodule

// File: tb/tb_hls_handshake_profiler.sv
// Scoreboard bench for hls_handshake_profiler (NUM_CH=3, CNT_W=4, LAT_W=8).
// Reads push an expected record; a negedge monitor pops it on rd_valid.
module tb_hls_handshake_profiler;

    localparam int NCH = 3;
    localparam int CW  = 4;
    localparam int LW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           finish = 1'b0, clear = 1'b0;
    logic [NCH-1:0] st = '0, rdy = '0, dn = '0, ct = '1;
    logic           rd_req = 1'b0;
    logic [1:0]     rd_ch = '0;
    logic           rd_valid, rd_err, rd_ovf, frozen;
    logic [CW-1:0]  rd_txn, rd_rdc, rd_busy, rd_stall;
    logic [LW-1:0]  rd_min, rd_max;

    typedef struct {
        logic [63:0] err, txn, rdc, busy, stall, mn, mx, ovf;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    hls_handshake_profiler #(.NUM_CH(NCH), .CNT_W(CW), .LAT_W(LW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .finish_i(finish), .clear_i(clear),
        .ap_start_i(st), .ap_ready_i(rdy), .ap_done_i(dn), .ap_continue_i(ct),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch), .rd_valid_o(rd_valid), .rd_err_o(rd_err),
        .rd_txn_o(rd_txn), .rd_ready_cnt_o(rd_rdc), .rd_busy_o(rd_busy),
        .rd_stall_o(rd_stall), .rd_lat_min_o(rd_min), .rd_lat_max_o(rd_max),
        .rd_ovf_o(rd_ovf), .frozen_o(frozen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(int err, int txn, int rdc, int busy, int stall,
                                int mn, int mx, int ovf, bit chk_lat);
        exp_t e;
        e.err = 64'(err);  e.txn = 64'(txn);     e.rdc = 64'(rdc);
        e.busy = 64'(busy); e.stall = 64'(stall); e.mn = 64'(mn);
        e.mx = 64'(mx);    e.ovf = 64'(ovf);     e.chk_lat = chk_lat;
        return e;
    endfunction

    // Issue a read; also checks that rd_valid is a single-cycle pulse.
    task automatic rd(input int ch, input exp_t e);
        sb.push_back(e);
        rd_req = 1'b1;
        rd_ch  = 2'(ch);
        tick();
        rd_req = 1'b0;
        check("rd_valid_rise", 64'(rd_valid), 64'd1);
        tick();
        check("rd_valid_pulse", 64'(rd_valid), 64'd0);
    endtask

    // Monitor: compare every presented readout against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: rd_valid with no expected read");
            end else begin
                e = sb.pop_front();
                check("rd_err",   64'(rd_err),   e.err);
                check("rd_txn",   64'(rd_txn),   e.txn);
                check("rd_ready", 64'(rd_rdc),   e.rdc);
                check("rd_busy",  64'(rd_busy),  e.busy);
                check("rd_stall", 64'(rd_stall), e.stall);
                check("rd_ovf",   64'(rd_ovf),   e.ovf);
                if (e.chk_lat) begin
                    check("rd_lat_min", 64'(rd_min), e.mn);
                    check("rd_lat_max", 64'(rd_max), e.mx);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        check("rst_valid",  64'(rd_valid), 64'd0);
        check("rst_txn",    64'(rd_txn),   64'd0);
        check("rst_latmin", 64'(rd_min),   64'd0);
        check("rst_frozen", 64'(frozen),   64'd0);
        rst_n = 1'b1;
        tick();
        rd(0, mk(0, 0, 0, 0, 0, 255, 0, 0, 1));

        // ch0: 5-cycle run, continue high
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        repeat (3) tick();
        dn[0] = 1'b1; rdy[0] = 1'b1; tick(); dn[0] = 1'b0; rdy[0] = 1'b0;
        tick();
        rd(0, mk(0, 1, 1, 5, 0, 5, 5, 0, 1));

        // ch1: latency 3, continue low for 4 cycles
        ct[1] = 1'b0;
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        tick();
        dn[1] = 1'b1; tick(); dn[1] = 1'b0;
        repeat (4) tick();
        ct[1] = 1'b1; tick();
        tick();
        rd(1, mk(0, 1, 0, 3, 4, 3, 3, 0, 1));
        // ch1: second run, latency 7
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        repeat (5) tick();
        dn[1] = 1'b1; tick(); dn[1] = 1'b0;
        tick();
        rd(1, mk(0, 2, 0, 10, 4, 3, 7, 0, 1));

        // ch2: three back-to-back 4-cycle runs with start held
        st[2] = 1'b1;
        repeat (3) tick();
        dn[2] = 1'b1; tick(); dn[2] = 1'b0;
        repeat (3) tick();
        dn[2] = 1'b1; tick(); dn[2] = 1'b0;
        repeat (3) tick();
        st[2] = 1'b0; dn[2] = 1'b1; tick(); dn[2] = 1'b0;
        tick();
        rd(2, mk(0, 3, 0, 12, 0, 0, 0, 0, 0));

        // out-of-range channel
        rd(3, mk(1, 0, 0, 0, 0, 0, 0, 0, 1));

        // freeze mid-run on ch1: two busy cycles count, then nothing changes
        st[1] = 1'b1; tick(); st[1] = 1'b0;
        tick();
        finish = 1'b1; tick(); finish = 1'b0;
        check("frozen_set", 64'(frozen), 64'd1);
        dn[1] = 1'b1; rdy[1] = 1'b1; tick(); dn[1] = 1'b0; rdy[1] = 1'b0;
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        dn[0] = 1'b1; tick(); dn[0] = 1'b0;
        tick();
        rd(1, mk(0, 2, 0, 12, 4, 3, 7, 0, 1));
        rd(0, mk(0, 1, 1, 5, 0, 5, 5, 0, 1));
        check("frozen_hold", 64'(frozen), 64'd1);

        // clear together with finish: clear wins
        clear = 1'b1; finish = 1'b1; tick(); clear = 1'b0; finish = 1'b0;
        check("frozen_clear", 64'(frozen), 64'd0);
        rd(1, mk(0, 0, 0, 0, 0, 255, 0, 0, 1));
        rd(2, mk(0, 0, 0, 0, 0, 255, 0, 0, 1));

        // saturation on ch0: 21 back-to-back completions into 4-bit counters
        st[0] = 1'b1; dn[0] = 1'b1; rdy[0] = 1'b1;
        repeat (21) tick();
        st[0] = 1'b0; rdy[0] = 1'b0; tick();
        dn[0] = 1'b0; tick();
        rd(0, mk(0, 15, 15, 15, 0, 0, 0, 1, 0));

        // async reset mid-run, between clock edges
        st[0] = 1'b1; tick(); st[0] = 1'b0;
        tick();
        rd(0, mk(0, 15, 15, 15, 0, 0, 0, 1, 0));
        check("pre_rst_txn", 64'(rd_txn), 64'd15);
        #2 rst_n = 1'b0;
        #1;
        check("arst_txn",    64'(rd_txn),  64'd0);
        check("arst_busy",   64'(rd_busy), 64'd0);
        check("arst_ovf",    64'(rd_ovf),  64'd0);
        check("arst_valid",  64'(rd_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        dn[0] = 1'b1; tick(); dn[0] = 1'b0;
        tick();
        rd(0, mk(0, 0, 0, 0, 0, 255, 0, 0, 1));

        tick();
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
